// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit sampling, one-cycle
// valid_o / frame_err_o strobes, and a break-safe wait for the line to recover.
`timescale 1ns/1ps
module uart_rx #(
  parameter logic [15:0] BAUD_CNT_MAX = 16'd5208,
  parameter logic [15:0] HALF_CNT     = BAUD_CNT_MAX / 16'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_rx_s;
  logic        r_rx_d;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_frame_err;

  logic w_fe;
  logic w_half;
  logic w_bit_end;

  assign w_fe      = r_rx_d & ~r_rx_s;
  assign w_half    = (r_baud_cnt == HALF_CNT);
  assign w_bit_end = (r_baud_cnt == BAUD_CNT_MAX);

  // Synchroniser and edge-detect flops reset high so an idle line never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= Rx_i;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_baud_cnt  <= 16'd0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_baud_cnt <= 16'd0;
          if (w_fe) begin
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_half) begin
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 3'd0;
            // A line already back high at mid-start was a glitch, not a frame.
            r_state    <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_shift    <= {r_rx_s, r_shift[7:1]};
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= 16'd0;
            if (r_rx_s) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
          end
        end

        S_WAIT_IDLE: begin
          // Holding here through a break keeps a long low line to one error pulse.
          r_baud_cnt <= 16'd0;
          if (r_rx_s) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_baud_cnt <= 16'd0;
        end
      endcase
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign frame_err_o = r_frame_err;
  assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a fast instance (P=16) driven by directed and random frames
// and scored against a frame-level model, plus a default-rate instance for exact timing.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int P_FAST    = 16;
  localparam int HALF_FAST = 7;
  localparam int P_SLOW    = 5209;
  localparam int HALF_SLOW = 2604;
  // Negedge on which the start bit is driven -> negedge on which the strobe is seen:
  // two synchroniser cycles, edge detect, START entry, then HALF + 9 bit periods, then the output register.
  localparam int LAT_FAST  = 4 + HALF_FAST + 9 * P_FAST;
  localparam int LAT_SLOW  = 4 + HALF_SLOW + 9 * P_SLOW;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_fast = 1'b1;
  logic       rx_slow = 1'b1;
  logic [7:0] data_f, data_s;
  logic       valid_f, valid_s, ferr_f, ferr_s, busy_f, busy_s;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int slow_seen;
  bit slow_ferr;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_last = 8'h00;

  uart_rx #(.BAUD_CNT_MAX(16'd15)) u_fast (
    .clk(clk), .rst(rst), .Rx_i(rx_fast), .data_o(data_f),
    .valid_o(valid_f), .frame_err_o(ferr_f), .busy_o(busy_f)
  );

  uart_rx u_slow (
    .clk(clk), .rst(rst), .Rx_i(rx_slow), .data_o(data_s),
    .valid_o(valid_s), .frame_err_o(ferr_s), .busy_o(busy_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input bit slow, input logic v);
    if (slow) rx_slow = v;
    else      rx_fast = v;
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; a low stop bit is held for low_hold cycles.
  task automatic drive_frame(input bit slow, input logic [7:0] b, input bit stop_bit, input int low_hold);
    int         p;
    logic [9:0] bits;
    p    = slow ? P_SLOW : P_FAST;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_line(slow, bits[i]);
      if (i == 9 && !stop_bit) wait_neg(low_hold);
      else                     wait_neg(p);
    end
    set_line(slow, 1'b1);
  endtask

  // Model: a good frame yields its byte one strobe at start+LAT; a bad stop bit yields
  // an error strobe at the same time with data_o still holding the previous good byte.
  task automatic send_expect(input logic [7:0] b, input bit stop_bit, input int low_hold);
    exp_t e;
    e.is_err = !stop_bit;
    e.data   = stop_bit ? b : model_last;
    e.at     = cyc + LAT_FAST;
    exp_q.push_back(e);
    if (stop_bit) model_last = b;
    $display("tx byte=%02h stop=%0b expect %s at cycle %0d", b, stop_bit,
             stop_bit ? "valid" : "frame_err", e.at);
    drive_frame(1'b0, b, stop_bit, low_hold);
  endtask

  always @(negedge clk) begin
    if (rst && (valid_f || ferr_f)) begin
      exp_t e;
      check("exclusive_strobes", {31'd0, valid_f & ferr_f}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual valid=%0b ferr=%0b data=%02h required none (cycle %0d)",
                 valid_f, ferr_f, data_f, cyc);
      end else begin
        e = exp_q.pop_front();
        $display("rx valid=%0b ferr=%0b data=%02h cycle=%0d", valid_f, ferr_f, data_f, cyc);
        check("strobe_kind", {31'd0, ferr_f}, {31'd0, e.is_err});
        check("strobe_data", {24'd0, data_f}, {24'd0, e.data});
        check("strobe_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit stop;
    logic [7:0] b;

    wait_neg(3);
    check("reset_data", {24'd0, data_f}, 32'd0);
    check("reset_valid", {31'd0, valid_f}, 32'd0);
    check("reset_ferr", {31'd0, ferr_f}, 32'd0);
    check("reset_busy", {31'd0, busy_f}, 32'd0);
    check("reset_busy_slow", {31'd0, busy_s}, 32'd0);
    rst = 1'b1;
    wait_neg(4);

    // Plain frame
    send_expect(8'hA5, 1'b1, 0);
    wait_neg(3 * P_FAST);
    check("a5_busy_after", {31'd0, busy_f}, 32'd0);
    check("a5_drained", exp_q.size(), 32'd0);

    // Three-cycle low glitch rejected at mid-start
    n = cyc;
    rx_fast = 1'b0;
    wait_neg(3);
    rx_fast = 1'b1;
    check("glitch_busy_high", {31'd0, busy_f}, 32'd1);
    wait_neg(n + 11 - cyc);
    check("glitch_busy_low", {31'd0, busy_f}, 32'd0);
    wait_neg(3 * P_FAST);

    // Bad stop bit followed by a 40-cycle low line
    fork
      send_expect(8'h3C, 1'b0, 40);
      begin
        wait_neg(9 * P_FAST + 35);
        check("break_busy_wait", {31'd0, busy_f}, 32'd1);
      end
    join
    wait_neg(4);
    check("break_busy_low", {31'd0, busy_f}, 32'd0);
    check("break_data_hold", {24'd0, data_f}, 32'hA5);

    // Back-to-back frames, second start bit directly after the first stop bit
    send_expect(8'h55, 1'b1, 0);
    send_expect(8'hAA, 1'b1, 0);
    wait_neg(3 * P_FAST);
    check("b2b_drained", exp_q.size(), 32'd0);

    // Reset mid-frame: no strobes for the partial frame
    fork
      drive_frame(1'b0, 8'hFF, 1'b1, 0);
      begin
        wait_neg(4 * P_FAST + P_FAST / 2);
        rst = 1'b0;
        wait_neg(2);
        check("midrst_data", {24'd0, data_f}, 32'd0);
        check("midrst_busy", {31'd0, busy_f}, 32'd0);
        rst = 1'b1;
      end
    join
    model_last = 8'h00;
    wait_neg(P_FAST);
    check("postrst_data", {24'd0, data_f}, 32'd0);
    send_expect(8'h81, 1'b1, 0);
    wait_neg(3 * P_FAST);

    // Random frames with random gaps, some with a bad stop bit
    for (int k = 0; k < 12; k++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      if (stop) begin
        send_expect(b, 1'b1, 0);
        wait_neg($urandom_range(0, 2 * P_FAST));
      end else begin
        send_expect(b, 1'b0, P_FAST + $urandom_range(0, 40));
        wait_neg(3 + $urandom_range(0, P_FAST));
      end
    end
    wait_neg(3 * P_FAST);
    check("random_drained", exp_q.size(), 32'd0);

    // Default bit period: exact strobe time for 0x01
    n = cyc;
    slow_seen = -1;
    slow_ferr = 1'b0;
    fork
      drive_frame(1'b1, 8'h01, 1'b1, 0);
      begin
        for (int i = 0; i < 60000 && slow_seen < 0; i++) begin
          @(negedge clk);
          if (ferr_s) slow_ferr = 1'b1;
          if (valid_s) begin
            slow_seen = cyc;
            $display("rx slow valid data=%02h cycle=%0d", data_s, cyc);
            check("slow_data", {24'd0, data_s}, 32'h01);
          end
        end
        @(negedge clk);
        check("slow_pulse_width", {31'd0, valid_s}, 32'd0);
      end
    join
    check("slow_latency", slow_seen - n, LAT_SLOW);
    check("slow_no_ferr", {31'd0, slow_ferr}, 32'd0);
    wait_neg(4);
    check("slow_busy_low", {31'd0, busy_s}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the receive-side counterpart of the team's UART transmitter. Runs at the same bit period, so a TX→RX loopback works with identical parameters.
- Synchronises the asynchronous serial line and detects the start bit. Samples each bit at mid-bit and delivers each received byte with a one-cycle strobe to the SoC peripheral bus.
- Flags stop-bit (framing) errors.

Parameters:
- BAUD_CNT_MAX, 16'd5208: last value of the bit counter. Bit period P = BAUD_CNT_MAX+1 clk cycles (50 MHz / 9600 baud).
- HALF_CNT, BAUD_CNT_MAX/2 (integer division, 2604): wait in cycles from start-edge detection to the start-bit mid-sample.

Ports:
- clk, in, 1: system clock; single clock domain.
- rst, in, 1: reset; asynchronous, active-low.
- Rx_i, in, 1: serial line; asynchronous to clk; idle high.
- data_o, out, 8: last correctly received byte, LSB first on the line.
- valid_o, out, 1: one-cycle pulse; data_o is new.
- frame_err_o, out, 1: one-cycle pulse; stop bit sampled low.
- busy_o, out, 1: high whenever state ≠ IDLE.

Behaviour:
- Reset (rst low, async): state=IDLE, counters=0, data_o=8'h00, valid_o=0, frame_err_o=0, busy_o=0. Both synchroniser flops and the edge-detect flop reset to 1 (line idle).
- Sync: Rx_i passes through a 2-flop synchroniser into rx_s. rx_d is rx_s delayed one cycle. Falling edge fe = rx_d & ~rx_s.
- Counter: 16-bit baud_cnt, cleared on every state entry, incremented each cycle in START/DATA/STOP.
- State IDLE: on fe, go to START with baud_cnt=0 (call this cycle t0). Otherwise stay.
- State START: when baud_cnt==HALF_CNT (t0+HALF_CNT), sample rx_s.
  - rx_s==0: go to DATA, baud_cnt=0, bit_idx=0.
  - rx_s==1: glitch; return to IDLE. No outputs.
- State DATA: when baud_cnt==BAUD_CNT_MAX, shift rx_s into shift[7] (right shift, LSB first), clear baud_cnt, increment bit_idx. After the 8th sample (bit_idx==7), go to STOP.
  - Data bit k is sampled at t0+HALF_CNT+(k+1)·P, k=0..7.
- State STOP: sample at baud_cnt==BAUD_CNT_MAX (t0+HALF_CNT+9·P).
  - rx_s==1: on the next cycle data_o<=shift and valid_o=1 for exactly one cycle; go to IDLE.
  - rx_s==0: frame_err_o=1 for one cycle; data_o unchanged; go to WAIT_IDLE.
- State WAIT_IDLE: stay until rx_s==1, then go to IDLE. A held-low line (break) therefore produces exactly one frame_err_o and no spurious frames.
- Re-arm: return to IDLE happens at mid-stop-bit, so a new start edge up to half a bit early is accepted. Back-to-back frames with no idle gap are received.
- valid_o and frame_err_o are never high in the same cycle. Each pulse is exactly 1 cycle wide.
- data_o holds its value until the next valid_o. There is no overrun detection; the consumer must capture on valid_o.
- busy_o is combinational from state. It is high from the cycle after fe through the cycle the state returns to IDLE.
- rst asserted mid-frame: immediate abort to reset values. No valid_o or frame_err_o for the partial frame.
- Rx_i activity while in START/DATA/STOP is only observed at sample points. No re-synchronisation occurs mid-frame.
- Widths: baud_cnt 16 bits, with no wrap in normal operation because it is cleared at BAUD_CNT_MAX. bit_idx 3 bits.

Test Plan:
- Loopback 0xA5 from the UART transmitter, BAUD_CNT_MAX=15 (P=16, HALF_CNT=7) → exactly one valid_o pulse, data_o=8'hA5, frame_err_o never high, busy_o low afterwards.
- Rx_i low for 3 cycles, then high → START glitch reject: no valid_o or frame_err_o, state back to IDLE, busy_o low before t0+9.
- Frame 0x3C with stop bit driven low, line held low 40 cycles, then high → one frame_err_o pulse, no valid_o, data_o keeps its previous value, busy_o stays high until the line returns high (WAIT_IDLE).
- Back-to-back 0x55 then 0xAA, second start bit directly after the stop bit → two valid_o pulses, data_o=8'h55 then 8'hAA, exactly 10·P cycles apart.
- rst pulsed low at bit 4 of a 0xFF frame, then a clean 0x81 frame → no output for the aborted frame; after reset data_o=8'h00; next frame yields valid_o with data_o=8'h81.
- Timing check, default BAUD_CNT_MAX=5208: 0x01 frame → valid_o exactly 1 cycle after the stop sample at t0+2604+9·5209.
